dp_class_denoiser: RTL and testbench
====================================

# dp_class_denoiser

Authorized-side counterpart of the differential-privacy noise injector. Accepts obfuscated 4-bit CNN class results over a valid/ready stream and regenerates the injector's LFSR keystream from a shared seed. Strips the noise from each result and buffers recovered classes in a small FIFO for the trusted RISC-V core. Detects keystream desynchronization through repeated out-of-range classes.

## Interface

Parameters:
- DEPTH, 4: output FIFO entries; power of two, 2..16.
- NUM_CLASSES, 10: valid classes are 0..NUM_CLASSES-1.
- ERR_LIMIT, 3: consecutive range errors that declare lock lost.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- seed_load  in  1  one-cycle pulse; load keystream seed
- seed  in  4  seed value; 4'h0 is replaced by 4'hF
- in_valid  in  1  obfuscated sample valid
- in_ready  out  1  sample accepted when in_valid && in_ready
- in_class  in  4  obfuscated class
- in_noised  in  1  1 = sample was XORed with keystream
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer pop
- out_class  out  4  recovered class
- out_err  out  1  recovered class >= NUM_CLASSES
- lock_lost  out  1  state == LOST

## Operation

- Keystream: 4-bit LFSR, step next = {l[2:0], l[3]^l[1]}, reset 4'hF. Period-6 sequence from F: F, E, C, 9, 3, 7.
- The LFSR advances once per accepted sample, regardless of in_noised.
- Recovered class = in_noised ? in_class ^ lfsr : in_class, using the current (pre-advance) LFSR value.
- err = recovered >= NUM_CLASSES. The err bit is pushed with the class.
- Error counter, 0..ERR_LIMIT:
  - increments on an accepted err sample, saturating;
  - clears on an accepted good sample.
- FSM states:
  - IDLE: after reset; in_ready=0. Goes to RUN on seed_load.
  - RUN: in_ready = !fifo_full. Goes to LOST when the counter reaches ERR_LIMIT (evaluated on the accepting edge).
  - LOST: in_ready=0; FIFO still drains. Goes to RUN on seed_load.
- seed_load in any state (including RUN):
  - LFSR <= seed (4'h0 becomes 4'hF);
  - error counter <= 0;
  - state <= RUN;
  - FIFO is not flushed.
- A sample offered in the same cycle as seed_load is not accepted; in_ready is forced low that cycle.
- FIFO: first-word-fall-through. out_class/out_err are valid whenever out_valid is high.

## Timing

- Reset values:
  - state=IDLE, lfsr=4'hF, counter=0, FIFO empty;
  - in_ready=0, out_valid=0, out_class=0, out_err=0, lock_lost=0.
- Latency: a sample accepted at edge N appears with out_valid=1 after edge N (one cycle).
- Full FIFO: in_ready=0. A pop on the same edge does not enable a push that cycle (in_ready depends only on registered state).
- Empty FIFO with simultaneous push: no bypass; the data is visible the next cycle.
- Simultaneous push and pop when neither full nor empty: occupancy unchanged.
- Pointers wrap modulo DEPTH. Occupancy counter is $clog2(DEPTH)+1 bits.
- lock_lost rises the cycle after the ERR_LIMIT-th error is accepted. It falls the cycle after seed_load.
- Asynchronous reset mid-stream discards FIFO contents and keystream position.

## Configuration

- DP_DENOISE_STATS_EN defined:
  - adds outputs stat_samples[15:0] (accepted samples) and stat_errors[15:0] (accepted err samples);
  - both saturate at 16'hFFFF, reset to 0, and are not cleared by seed_load.
- Undefined: these ports and counters do not exist.

## Structure

- Package dp_pkg holds:
  - class_t (logic [3:0]);
  - DP_LFSR_RESET = 4'hF;
  - function dp_lfsr_next(logic [3:0]), which the injector side also uses;
  - state enum {IDLE, RUN, LOST}.
- Sub-module dp_keystream_lfsr: seed load, advance enable, zero-seed substitution.
- The FIFO is inline.

## Test plan

- Reset, no seed: in_valid=1 -> in_ready stays 0 and no output.
- Seed 4'hF, then samples (C,noised), (E,noised), (5,clean) -> out_class 3, 0, 5; out_err 0; each visible one cycle after acceptance.
- Seed 4'h0 -> behaves as seed F: first noised C recovers 3.
- DEPTH=4, out_ready=0, six samples offered -> four accepted and in_ready=0. Then raise out_ready -> in-order drain, and in_ready returns the cycle after the first pop.
- Three consecutive noised samples recovering to values >= 10 -> lock_lost=1 and in_ready=0. Then seed_load 4'hE -> lock_lost=0, and noised E recovers 0.
- With DP_DENOISE_STATS_EN: 5 samples including 2 errors -> stat_samples=5, stat_errors=2; unchanged after seed_load.

Source files
------------

// File: rtl/dp_class_denoiser_pkg.sv
// Shared definitions for the differential-privacy denoiser (and the injector
// side that shares the keystream function).
//   class_t         : 4-bit CNN class value
//   DP_LFSR_RESET   : keystream value after reset or a zero seed
//   state_t         : denoiser lock state {IDLE, RUN, LOST}
//   dp_lfsr_next()  : one keystream step
package dp_pkg;

   typedef logic [3:0] class_t;

   localparam class_t DP_LFSR_RESET = 4'hF;

   typedef enum logic [1:0] {IDLE, RUN, LOST} state_t;

   // Period-6 sequence from F: F, E, C, 9, 3, 7.
   function automatic class_t dp_lfsr_next(input class_t l);
      return {l[2:0], l[3] ^ l[1]};
   endfunction

endpackage

// File: rtl/dp_class_denoiser_if.sv
// Stream bundle for the denoiser.
//   in_valid/in_ready/in_class/in_noised : obfuscated sample stream
//   out_valid/out_ready/out_class/out_err : recovered class stream (FIFO head)
// master = producer/consumer side (testbench or SoC glue), slave = denoiser.
interface dp_class_denoiser_if;
   import dp_pkg::*;

   logic   in_valid;
   logic   in_ready;
   class_t in_class;
   logic   in_noised;
   logic   out_valid;
   logic   out_ready;
   class_t out_class;
   logic   out_err;

   modport master (
      output in_valid, in_class, in_noised, out_ready,
      input  in_ready, out_valid, out_class, out_err
   );

   modport slave (
      input  in_valid, in_class, in_noised, out_ready,
      output in_ready, out_valid, out_class, out_err
   );

endinterface

// File: rtl/dp_class_denoiser_lfsr.sv
// Keystream regenerator: 4-bit LFSR mirroring the noise injector.
//   clk, resetn : clock, asynchronous active-low reset (value -> DP_LFSR_RESET)
//   load, seed  : load seed; a zero seed would lock the LFSR, so it becomes F
//   advance     : step once (one accepted sample)
//   value       : current keystream nibble
module dp_keystream_lfsr
   import dp_pkg::*;
(
   input  logic   clk,
   input  logic   resetn,
   input  logic   load,
   input  class_t seed,
   input  logic   advance,
   output class_t value
);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         value <= DP_LFSR_RESET;
      end else if (load) begin
         value <= (seed == 4'h0) ? DP_LFSR_RESET : seed;
      end else if (advance) begin
         value <= dp_lfsr_next(value);
      end
   end

endmodule

// File: rtl/dp_class_denoiser.sv
// Authorized-side denoiser: strips keystream noise from obfuscated class
// results, buffers them in a first-word-fall-through FIFO and flags lock loss
// after ERR_LIMIT consecutive out-of-range classes.
//   clk, resetn     : clock, asynchronous active-low reset
//   seed_load, seed : (re)synchronise keystream and enter RUN
//   bus (slave)     : in_* sample stream, out_* recovered class stream
//   lock_lost       : high while in LOST
//   stat_samples, stat_errors : only when DP_DENOISE_STATS_EN is defined
module dp_class_denoiser
   import dp_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int NUM_CLASSES = 10,
   parameter int ERR_LIMIT   = 3
)(
   input  logic                clk,
   input  logic                resetn,
   input  logic                seed_load,
   input  class_t              seed,
   dp_class_denoiser_if.slave  bus,
   output logic                lock_lost
`ifdef DP_DENOISE_STATS_EN
   ,
   output logic [15:0]         stat_samples,
   output logic [15:0]         stat_errors
`endif
);

   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = PW + 1;
   localparam int ECW = $clog2(ERR_LIMIT + 1);

   state_t         state, state_next;
   class_t         lfsr;
   class_t         recovered;
   logic           is_err;
   logic           ready;
   logic           accept;
   logic           pop;
   logic [ECW-1:0] err_cnt, err_cnt_next;

   class_t         mem     [DEPTH];
   logic           mem_err [DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;
   logic           full, empty;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // Ready only from registered state so a same-edge pop never frees a slot.
   assign ready        = (state == RUN) && !full && !seed_load;
   assign bus.in_ready = ready;
   assign accept       = bus.in_valid && ready;
   assign pop          = !empty && bus.out_ready;

   assign recovered = bus.in_noised ? (bus.in_class ^ lfsr) : bus.in_class;
   assign is_err    = ({1'b0, recovered} >= 5'(NUM_CLASSES));

   dp_keystream_lfsr u_lfsr (
      .clk     (clk),
      .resetn  (resetn),
      .load    (seed_load),
      .seed    (seed),
      .advance (accept),
      .value   (lfsr)
   );

   always_comb begin
      err_cnt_next = err_cnt;
      if (seed_load) begin
         err_cnt_next = '0;
      end else if (accept) begin
         if (!is_err) begin
            err_cnt_next = '0;
         end else if (err_cnt != ECW'(ERR_LIMIT)) begin
            err_cnt_next = err_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: state_next = IDLE;
         RUN: begin
            if (accept && (err_cnt_next == ECW'(ERR_LIMIT))) begin
               state_next = LOST;
            end
         end
         LOST:    state_next = LOST;
         default: state_next = IDLE;
      endcase
      // Resync wins from any state, including RUN.
      if (seed_load) begin
         state_next = RUN;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         err_cnt <= '0;
      end else begin
         state   <= state_next;
         err_cnt <= err_cnt_next;
      end
   end

   assign lock_lost = (state == LOST);

   // Storage is not reset; out_* are gated by empty instead.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr]     <= recovered;
         mem_err[wr_ptr] <= is_err;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (accept && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !accept) begin
            count <= count - 1'b1;
         end
      end
   end

   assign bus.out_valid = !empty;
   assign bus.out_class = empty ? '0 : mem[rd_ptr];
   assign bus.out_err   = !empty && mem_err[rd_ptr];

`ifdef DP_DENOISE_STATS_EN
   // Lifetime counters: survive seed_load, saturate instead of wrapping.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stat_samples <= '0;
         stat_errors  <= '0;
      end else if (accept) begin
         if (stat_samples != 16'hFFFF) begin
            stat_samples <= stat_samples + 1'b1;
         end
         if (is_err && (stat_errors != 16'hFFFF)) begin
            stat_errors <= stat_errors + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dp_class_denoiser.sv
// Self-checking bench for dp_class_denoiser: directed scenarios plus a
// randomized run against a queue-based reference model.
// Define DP_DENOISE_STATS_EN to also exercise the statistics counters.
module tb_dp_class_denoiser;
   import dp_pkg::*;

   localparam int DEPTH       = 4;
   localparam int NUM_CLASSES = 10;
   localparam int ERR_LIMIT   = 3;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       seed_load = 1'b0;
   logic [3:0] seed = 4'h0;
   logic       lock_lost;
`ifdef DP_DENOISE_STATS_EN
   logic [15:0] stat_samples;
   logic [15:0] stat_errors;
`endif

   int errors = 0;
   int checks = 0;

   dp_class_denoiser_if bus ();

   dp_class_denoiser #(
      .DEPTH       (DEPTH),
      .NUM_CLASSES (NUM_CLASSES),
      .ERR_LIMIT   (ERR_LIMIT)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .seed_load (seed_load),
      .seed      (seed),
      .bus       (bus),
      .lock_lost (lock_lost)
`ifdef DP_DENOISE_STATS_EN
      ,
      .stat_samples (stat_samples),
      .stat_errors  (stat_errors)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: expected FIFO contents and keystream position.
   typedef struct packed {
      logic [3:0] c;
      logic       e;
   } ent_t;

   ent_t       q[$];
   logic [3:0] m_lfsr;
   int         m_cnt;
   bit         m_started;
   bit         m_lost;
   int         m_samples;
   int         m_errs;

   function automatic bit m_ready();
      return m_started && !m_lost && (q.size() < DEPTH) && !seed_load;
   endfunction

   task automatic model_reset();
      q.delete();
      m_lfsr    = 4'hF;
      m_cnt     = 0;
      m_started = 1'b0;
      m_lost    = 1'b0;
      m_samples = 0;
      m_errs    = 0;
   endtask

   // Called at negedge with inputs driven; returns at the following negedge.
   task automatic tick();
      bit         acc;
      bit         pp;
      bit         sl;
      bit         e;
      logic [3:0] rec;
      logic [3:0] sd;
      acc = bus.in_valid && m_ready();
      pp  = (q.size() > 0) && bus.out_ready;
      rec = bus.in_noised ? (bus.in_class ^ m_lfsr) : bus.in_class;
      e   = int'(rec) >= NUM_CLASSES;
      sl  = seed_load;
      sd  = seed;
      @(posedge clk);
      if (pp) void'(q.pop_front());
      if (acc) begin
         q.push_back({rec, e});
         m_lfsr = {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[1]};
         if (e) m_cnt = (m_cnt < ERR_LIMIT) ? m_cnt + 1 : m_cnt;
         else   m_cnt = 0;
         if (m_cnt >= ERR_LIMIT) m_lost = 1'b1;
         if (m_samples < 65535) m_samples++;
         if (e && m_errs < 65535) m_errs++;
      end
      if (sl) begin
         m_lfsr    = (sd == 4'h0) ? 4'hF : sd;
         m_cnt     = 0;
         m_started = 1'b1;
         m_lost    = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.in_valid  = 1'b0;
      bus.in_class  = 4'h0;
      bus.in_noised = 1'b0;
      seed_load     = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      idle_inputs();
      bus.out_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic load_seed(input logic [3:0] s);
      bus.in_valid = 1'b0;
      seed_load    = 1'b1;
      seed         = s;
      tick();
      seed_load    = 1'b0;
   endtask

   task automatic send(input logic [3:0] c, input logic n);
      bus.in_valid  = 1'b1;
      bus.in_class  = c;
      bus.in_noised = n;
      tick();
      bus.in_valid  = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      bus.in_valid = 1'b1;
      bus.in_class = 4'h3;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (bus.in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_in_ready: got %b want 0", bus.in_ready);
         end
         checks++;
         if (bus.out_valid !== 1'b0 || bus.out_class !== 4'h0 || bus.out_err !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_out: got v=%b c=%h e=%b want 0/0/0",
                               bus.out_valid, bus.out_class, bus.out_err);
         end
         checks++;
         if (lock_lost !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_lock_lost: got %b want 0", lock_lost);
         end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_directed();
      logic [3:0] cls [3];
      logic       nz  [3];
      logic [3:0] exp [3];
      cls = '{4'hC, 4'hE, 4'h5};
      nz  = '{1'b1, 1'b1, 1'b0};
      exp = '{4'h3, 4'h0, 4'h5};
      do_reset();
      load_seed(4'hF);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send(cls[i], nz[i]);
         #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_class !== exp[i] || bus.out_err !== 1'b0) begin
            errors++; $display("[TB] FAIL directed_%0d: got v=%b c=%h e=%b want 1/%h/0",
                               i, bus.out_valid, bus.out_class, bus.out_err, exp[i]);
         end
      end
      tick();
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL directed_drained: got out_valid=%b want 0", bus.out_valid);
      end
   endtask

   task automatic test_zero_seed();
      do_reset();
      load_seed(4'h0);
      bus.out_ready = 1'b1;
      send(4'hC, 1'b1);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_class !== 4'h3) begin
         errors++; $display("[TB] FAIL zero_seed: got v=%b c=%h want 1/3", bus.out_valid, bus.out_class);
      end
      tick();
   endtask

   task automatic test_seed_collision();
      do_reset();
      load_seed(4'hF);
      bus.out_ready = 1'b1;
      send(4'hC, 1'b1);
      tick();
      bus.in_valid  = 1'b1;
      bus.in_class  = 4'h5;
      bus.in_noised = 1'b0;
      seed_load     = 1'b1;
      seed          = 4'hF;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL collision_ready: got %b want 0", bus.in_ready);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL collision_accepted: got out_valid=%b want 0", bus.out_valid);
      end
      send(4'hC, 1'b1);
      #1;
      checks++;
      if (bus.out_class !== 4'h3) begin
         errors++; $display("[TB] FAIL collision_reload: got %h want 3", bus.out_class);
      end
      tick();
   endtask

   task automatic test_full();
      int accepted;
      do_reset();
      load_seed(4'hF);
      bus.out_ready = 1'b0;
      accepted = 0;
      for (int i = 0; i < 6; i++) begin
         bus.in_valid  = 1'b1;
         bus.in_class  = 4'(i);
         bus.in_noised = 1'b0;
         #1;
         if (bus.in_ready === 1'b1) accepted++;
         tick();
      end
      idle_inputs();
      #1;
      checks++;
      if (accepted != DEPTH || bus.in_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL full_accept: got accepted=%0d ready=%b want %0d/0",
                            accepted, bus.in_ready, DEPTH);
      end
      bus.out_ready = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_class !== 4'(k)) begin
            errors++; $display("[TB] FAIL full_drain_%0d: got v=%b c=%h want 1/%h",
                               k, bus.out_valid, bus.out_class, 4'(k));
         end
         tick();
         if (k == 0) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
               errors++; $display("[TB] FAIL full_ready_return: got %b want 1", bus.in_ready);
            end
         end
      end
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL full_empty: got out_valid=%b want 0", bus.out_valid);
      end
   endtask

   task automatic test_lock();
      logic [3:0] exp [3];
      logic       ll  [3];
      exp = '{4'hF, 4'hE, 4'hC};
      ll  = '{1'b0, 1'b0, 1'b1};
      do_reset();
      load_seed(4'hF);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send(4'h0, 1'b1);
         #1;
         checks++;
         if (bus.out_class !== exp[i] || bus.out_err !== 1'b1 || lock_lost !== ll[i]) begin
            errors++; $display("[TB] FAIL lock_err_%0d: got c=%h e=%b lost=%b want %h/1/%b",
                               i, bus.out_class, bus.out_err, lock_lost, exp[i], ll[i]);
         end
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL lock_ready: got %b want 0", bus.in_ready);
      end
      load_seed(4'hE);
      #1;
      checks++;
      if (lock_lost !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL lock_resync: got lost=%b ready=%b want 0/1", lock_lost, bus.in_ready);
      end
      send(4'hE, 1'b1);
      #1;
      checks++;
      if (bus.out_class !== 4'h0 || bus.out_err !== 1'b0) begin
         errors++; $display("[TB] FAIL lock_recover: got c=%h e=%b want 0/0", bus.out_class, bus.out_err);
      end
      tick();
   endtask

   task automatic test_async_reset();
      do_reset();
      load_seed(4'h9);
      send(4'h1, 1'b0);
      send(4'h2, 1'b0);
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || lock_lost !== 1'b0) begin
         errors++; $display("[TB] FAIL async_reset: got v=%b ready=%b lost=%b want 0/0/0",
                            bus.out_valid, bus.in_ready, lock_lost);
      end
      model_reset();
      @(negedge clk);
      resetn = 1'b1;
   endtask

`ifdef DP_DENOISE_STATS_EN
   task automatic test_stats();
      do_reset();
      #1;
      checks++;
      if (stat_samples !== 16'd0 || stat_errors !== 16'd0) begin
         errors++; $display("[TB] FAIL stats_reset: got %0d/%0d want 0/0", stat_samples, stat_errors);
      end
      load_seed(4'hF);
      bus.out_ready = 1'b1;
      send(4'hC, 1'b1);
      send(4'h0, 1'b1);
      send(4'h5, 1'b0);
      send(4'hC, 1'b0);
      send(4'h1, 1'b0);
      #1;
      checks++;
      if (stat_samples !== 16'd5 || stat_errors !== 16'd2) begin
         errors++; $display("[TB] FAIL stats_count: got %0d/%0d want 5/2", stat_samples, stat_errors);
      end
      load_seed(4'h3);
      #1;
      checks++;
      if (stat_samples !== 16'd5 || stat_errors !== 16'd2) begin
         errors++; $display("[TB] FAIL stats_seed: got %0d/%0d want 5/2", stat_samples, stat_errors);
      end
   endtask
`endif

   task automatic test_random();
      bit         ev;
      logic [3:0] ec;
      logic       ee;
      do_reset();
      load_seed(4'($urandom_range(0, 15)));
      for (int n = 0; n < 400; n++) begin
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.in_class  = 4'($urandom_range(0, 15));
         bus.in_noised = 1'($urandom_range(0, 1));
         bus.out_ready = ($urandom_range(0, 1) == 1);
         seed_load     = ($urandom_range(0, 19) == 0);
         seed          = 4'($urandom_range(0, 15));
         #1;
         ev = q.size() > 0;
         ec = ev ? q[0].c : 4'h0;
         ee = ev ? q[0].e : 1'b0;
         checks++;
         if (bus.in_ready !== m_ready()) begin
            errors++; $display("[TB] FAIL rand_ready@%0d: got %b want %b", n, bus.in_ready, m_ready());
         end
         checks++;
         if (bus.out_valid !== ev || bus.out_class !== ec || bus.out_err !== ee) begin
            errors++; $display("[TB] FAIL rand_out@%0d: got v=%b c=%h e=%b want %b/%h/%b",
                               n, bus.out_valid, bus.out_class, bus.out_err, ev, ec, ee);
         end
         checks++;
         if (lock_lost !== m_lost) begin
            errors++; $display("[TB] FAIL rand_lock@%0d: got %b want %b", n, lock_lost, m_lost);
         end
`ifdef DP_DENOISE_STATS_EN
         checks++;
         if (int'(stat_samples) != m_samples || int'(stat_errors) != m_errs) begin
            errors++; $display("[TB] FAIL rand_stats@%0d: got %0d/%0d want %0d/%0d",
                               n, stat_samples, stat_errors, m_samples, m_errs);
         end
`endif
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      idle_inputs();
      bus.out_ready = 1'b0;
      model_reset();
      test_reset();
      test_directed();
      test_zero_seed();
      test_seed_collision();
      test_full();
      test_lock();
      test_async_reset();
`ifdef DP_DENOISE_STATS_EN
      test_stats();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
